// File: rtl/kyber_enc_loader_if.sv
// Host byte stream and kyber_pke_enc load-port bundle for kyber_enc_loader.
// master = loader side, slave = host/core side.
interface kyber_enc_loader_if #(
  parameter int IDX_W = 16
);
  logic             host_valid;
  logic [7:0]       host_data;
  logic             host_ready;
  logic [3:0]       host_type;
  logic             core_set;
  logic [3:0]       core_input_type;
  logic             core_readin;
  logic             core_readin_ok;
  logic [3:0]       core_data_type;
  logic [7:0]       core_din;
  logic [IDX_W-1:0] core_in_index;
  logic             core_full_in;
  logic             core_done;

  modport master (
    input  host_valid, host_data, core_input_type, core_readin_ok, core_done,
    output host_ready, host_type, core_set, core_readin, core_data_type,
           core_din, core_in_index, core_full_in
  );

  modport slave (
    output host_valid, host_data, core_input_type, core_readin_ok, core_done,
    input  host_ready, host_type, core_set, core_readin, core_data_type,
           core_din, core_in_index, core_full_in
  );
endinterface

// File: rtl/kyber_enc_loader.sv
// Load sequencer for kyber_pke_enc: answers the core's input_type requests by
// streaming the right number of host bytes through a one-entry output register.
module kyber_enc_loader #(
  parameter int LEN_R   = 32,
  parameter int LEN_EK  = 1184,
  parameter int LEN_M   = 32,
  parameter int LEN_AUX = 32,
  parameter int IDX_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  kyber_enc_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TYPE, S_LOAD, S_FULL, S_ERR
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       cur_type_q, cur_type_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] cnt_in_q, cnt_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             set_q, set_d;
  logic             readin_q, readin_d;
  logic             full_q, full_d;
  logic [3:0]       host_type_q, host_type_d;
  logic [3:0]       data_type_q, data_type_d;
  logic [7:0]       din_q, din_d;
  logic [IDX_W-1:0] index_q, index_d;

  logic host_xfer, core_xfer, last_xfer, in_session_q, in_session_d;

  function automatic logic [IDX_W-1:0] type_len(input logic [3:0] t);
    case (t)
      4'd1:    type_len = IDX_W'(LEN_R);
      4'd2:    type_len = IDX_W'(LEN_EK);
      4'd3:    type_len = IDX_W'(LEN_M);
      4'd4:    type_len = IDX_W'(LEN_AUX);
      default: type_len = '0;
    endcase
  endfunction

  // cnt_in saturates at len purely through host_ready.
  assign bus.host_ready = (state_q == S_LOAD) && (cnt_in_q < len_q) &&
                          (!readin_q || bus.core_readin_ok);
  assign host_xfer = bus.host_valid && bus.host_ready;
  assign core_xfer = readin_q && bus.core_readin_ok;
  assign last_xfer = core_xfer && (index_q == len_q - IDX_ONE);

  assign in_session_q = (state_q == S_WAIT_TYPE) || (state_q == S_LOAD) || (state_q == S_FULL);
  assign in_session_d = (state_d == S_WAIT_TYPE) || (state_d == S_LOAD) || (state_d == S_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_type_q  <= '0;
      len_q       <= '0;
      cnt_in_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      set_q       <= 1'b0;
      readin_q    <= 1'b0;
      full_q      <= 1'b0;
      host_type_q <= '0;
      data_type_q <= '0;
      din_q       <= '0;
      index_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_type_q  <= cur_type_d;
      len_q       <= len_d;
      cnt_in_q    <= cnt_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      set_q       <= set_d;
      readin_q    <= readin_d;
      full_q      <= full_d;
      host_type_q <= host_type_d;
      data_type_q <= data_type_d;
      din_q       <= din_d;
      index_q     <= index_d;
    end
  end

  // core_done outranks any type change seen in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_WAIT_TYPE;
      end
      S_WAIT_TYPE: begin
        if (bus.core_done)                                       state_d = S_IDLE;
        else if (bus.core_input_type inside {[4'd1:4'd4]})        state_d = S_LOAD;
        else if (bus.core_input_type != 4'd0)                     state_d = S_ERR;
      end
      S_LOAD: begin
        if (bus.core_done)                                        state_d = S_IDLE;
        else if (bus.core_input_type != cur_type_q)               state_d = S_ERR;
        else if (last_xfer)                                       state_d = S_FULL;
      end
      S_FULL: begin
        if (bus.core_done)                                        state_d = S_IDLE;
        else if (bus.core_input_type != cur_type_q)               state_d = S_WAIT_TYPE;
      end
      S_ERR: begin
        if (start) state_d = S_WAIT_TYPE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cur_type_d  = cur_type_q;
    len_d       = len_q;
    cnt_in_d    = cnt_in_q;
    readin_d    = readin_q;
    din_d       = din_q;
    index_d     = index_q;
    data_type_d = data_type_q;

    if ((state_q == S_WAIT_TYPE) && (state_d == S_LOAD)) begin
      cur_type_d  = bus.core_input_type;
      len_d       = type_len(bus.core_input_type);
      cnt_in_d    = '0;
      data_type_d = bus.core_input_type;
    end

    // Simultaneous host and core transfers reload the register with readin held high.
    if (state_d == S_LOAD) begin
      if (host_xfer) begin
        din_d    = bus.host_data;
        index_d  = cnt_in_q;
        readin_d = 1'b1;
        cnt_in_d = cnt_in_q + IDX_ONE;
      end else if (core_xfer) begin
        readin_d = 1'b0;
      end
    end else begin
      readin_d = 1'b0;
    end

    if (state_d == S_ERR) begin
      din_d       = '0;
      index_d     = '0;
      data_type_d = '0;
    end

    set_d       = in_session_d;
    busy_d      = in_session_d;
    done_d      = bus.core_done && in_session_q;
    err_d       = (state_d == S_ERR);
    full_d      = (state_q == S_LOAD) && (state_d == S_FULL);
    host_type_d = (state_d == S_LOAD) ? cur_type_d : 4'd0;
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;
  assign bus.host_type      = host_type_q;
  assign bus.core_set       = set_q;
  assign bus.core_readin    = readin_q;
  assign bus.core_data_type = data_type_q;
  assign bus.core_din       = din_q;
  assign bus.core_in_index  = index_q;
  assign bus.core_full_in   = full_q;

endmodule

// File: tb/tb_kyber_enc_loader.sv
// Directed testbench for kyber_enc_loader: host producer and core consumer
// are driven cycle by cycle, each scenario task checks its own results.
module tb_kyber_enc_loader;
  logic clk = 1'b0;
  logic reset, start;
  logic busy, done, err;
  int   n_cmp = 0;
  int   n_fail = 0;

  kyber_enc_loader_if #(.IDX_W(16)) ifc();

  kyber_enc_loader #(
    .LEN_R(32), .LEN_EK(1184), .LEN_M(32), .LEN_AUX(32), .IDX_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .err(err),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bval(input logic [3:0] t, input int i);
    return 8'(i * 7 + int'(t) * 13);
  endfunction

  function automatic logic [44:0] all_outs();
    return {busy, done, err, ifc.host_type, ifc.host_ready, ifc.core_set,
            ifc.core_readin, ifc.core_data_type, ifc.core_din,
            ifc.core_in_index, ifc.core_full_in};
  endfunction

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
  endtask

  task automatic finish_session();
    @(negedge clk);
    ifc.core_done = 1'b1; ifc.core_input_type = 4'd0; ifc.host_valid = 1'b0;
    @(negedge clk);
    ifc.core_done = 1'b0;
  endtask

  // Plays host and core for one input; returns per-byte error tallies.
  task automatic drive_load(input logic [3:0] t, input int len, input bit alt_ok,
                            input int stall_at, input int stall_len, input int abort_at,
                            output int recv, output int derr, output int serr,
                            output int nfull, output int gaps, output int lat,
                            output bit timeout);
    int hcnt, stall_left, cyc;
    bit started, seen_rd, prev_hold, fin;
    logic [7:0]  pdin;
    logic [15:0] pidx;
    recv = 0; derr = 0; serr = 0; nfull = 0; gaps = 0; lat = 0;
    hcnt = 0; stall_left = stall_len; cyc = 0;
    started = 0; seen_rd = 0; prev_hold = 0; fin = 0; pdin = '0; pidx = '0;
    for (int k = 0; k < 4 * len + 50; k++) begin
      @(negedge clk);
      ifc.core_input_type = t;
      ifc.core_readin_ok  = alt_ok ? ((k % 2) == 0) : 1'b1;
      if (stall_at >= 0 && hcnt == stall_at && stall_left > 0) begin
        ifc.host_valid = 1'b0;
        stall_left--;
      end else begin
        ifc.host_valid = 1'b1;
      end
      ifc.host_data = bval(t, hcnt);
      #1;
      if (started) cyc++;
      if (!started && ifc.host_type == t) begin started = 1; cyc = 1; end
      if (prev_hold && (ifc.core_readin !== 1'b1 || ifc.core_din !== pdin ||
                        ifc.core_in_index !== pidx)) serr++;
      if (seen_rd && !ifc.core_readin && !ifc.core_full_in) gaps++;
      if (ifc.core_readin === 1'b1) seen_rd = 1;
      if (ifc.core_full_in === 1'b1) begin
        nfull++;
        if (ifc.core_readin !== 1'b0) derr++;
        lat = cyc; fin = 1;
        break;
      end
      if (ifc.core_readin && ifc.core_readin_ok) begin
        if (ifc.core_in_index !== 16'(recv) || ifc.core_din !== bval(t, recv) ||
            ifc.core_data_type !== t) derr++;
        recv++;
      end
      prev_hold = ifc.core_readin && !ifc.core_readin_ok;
      pdin = ifc.core_din; pidx = ifc.core_in_index;
      if (ifc.host_valid && ifc.host_ready) hcnt++;
      if (abort_at > 0 && recv == abort_at) begin fin = 1; break; end
    end
    timeout = !fin;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
    reset = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_full_session();
    int len[4] = '{32, 1184, 32, 32};
    int recv, derr, serr, nfull, gaps, lat;
    bit to;
    do_start();
    n_cmp++; if (ifc.core_set !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL start_set: set=%b busy=%b want 1 1", ifc.core_set, busy); end
    for (int i = 0; i < 4; i++) begin
      drive_load(4'(i + 1), len[i], 1'b0, -1, 0, 0, recv, derr, serr, nfull, gaps, lat, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL full_timeout t%0d: got timeout want full_in", i + 1); end
      n_cmp++; if (recv !== len[i]) begin n_fail++; $display("FAIL full_count t%0d: got %0d want %0d", i + 1, recv, len[i]); end
      n_cmp++; if (derr !== 0) begin n_fail++; $display("FAIL full_bytes t%0d: got %0d bad bytes want 0", i + 1, derr); end
      n_cmp++; if (gaps !== 0) begin n_fail++; $display("FAIL full_bubble t%0d: got %0d gaps want 0", i + 1, gaps); end
      n_cmp++; if (lat !== len[i] + 2) begin n_fail++; $display("FAIL full_cycles t%0d: got %0d want %0d", i + 1, lat, len[i] + 2); end
      @(negedge clk); #1;
      n_cmp++; if (ifc.core_full_in !== 1'b0) begin n_fail++; $display("FAIL full_pulse t%0d: got %b want 0", i + 1, ifc.core_full_in); end
    end
    @(negedge clk);
    ifc.core_done = 1'b1; ifc.core_input_type = 4'd0; ifc.host_valid = 1'b0;
    @(negedge clk); ifc.core_done = 1'b0; #1;
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || ifc.core_set !== 1'b0) begin n_fail++; $display("FAIL done_end: done=%b busy=%b set=%b want 1 0 0", done, busy, ifc.core_set); end
    @(negedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b want 0", done); end
  endtask

  task automatic test_backpressure();
    int recv, derr, serr, nfull, gaps, lat;
    bit to;
    do_start();
    drive_load(4'd2, 1184, 1'b1, -1, 0, 0, recv, derr, serr, nfull, gaps, lat, to);
    n_cmp++; if (recv !== 1184 || to) begin n_fail++; $display("FAIL bp_count: got %0d (timeout %b) want 1184", recv, to); end
    n_cmp++; if (derr !== 0) begin n_fail++; $display("FAIL bp_order: got %0d bad bytes want 0", derr); end
    n_cmp++; if (serr !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable holds want 0", serr); end
    n_cmp++; if (nfull !== 1) begin n_fail++; $display("FAIL bp_full: got %0d want 1", nfull); end
    finish_session();
  endtask

  task automatic test_host_stall();
    int recv, derr, serr, nfull, gaps, lat;
    bit to;
    do_start();
    drive_load(4'd1, 32, 1'b0, 18, 5, 0, recv, derr, serr, nfull, gaps, lat, to);
    n_cmp++; if (recv !== 32 || nfull !== 1 || to) begin n_fail++; $display("FAIL stall_count: got %0d/%0d want 32/1", recv, nfull); end
    n_cmp++; if (derr !== 0) begin n_fail++; $display("FAIL stall_order: got %0d bad bytes want 0", derr); end
    n_cmp++; if (gaps !== 5) begin n_fail++; $display("FAIL stall_gap: got %0d idle cycles want 5", gaps); end
    finish_session();
  endtask

  task automatic test_type_change();
    int recv, derr, serr, nfull, gaps, lat;
    bit to;
    do_start();
    drive_load(4'd2, 1184, 1'b0, -1, 0, 100, recv, derr, serr, nfull, gaps, lat, to);
    n_cmp++; if (recv !== 100 || derr !== 0) begin n_fail++; $display("FAIL chg_pre: got %0d/%0d want 100/0", recv, derr); end
    @(negedge clk); ifc.core_input_type = 4'd3; ifc.host_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (err !== 1'b1 || ifc.core_set !== 1'b0) begin n_fail++; $display("FAIL chg_err: err=%b set=%b want 1 0", err, ifc.core_set); end
    n_cmp++; if (ifc.core_readin !== 1'b0 || ifc.host_ready !== 1'b0) begin n_fail++; $display("FAIL chg_quiet: readin=%b ready=%b want 0 0", ifc.core_readin, ifc.host_ready); end
    ifc.core_input_type = 4'd0;
    do_start();
    n_cmp++; if (err !== 1'b0 || ifc.core_set !== 1'b1) begin n_fail++; $display("FAIL chg_restart: err=%b set=%b want 0 1", err, ifc.core_set); end
    drive_load(4'd2, 1184, 1'b0, -1, 0, 0, recv, derr, serr, nfull, gaps, lat, to);
    n_cmp++; if (recv !== 1184 || derr !== 0 || to) begin n_fail++; $display("FAIL chg_reload: got %0d bytes %0d bad want 1184 0", recv, derr); end
    finish_session();
  endtask

  task automatic test_illegal_type();
    int rd = 0;
    do_start();
    @(negedge clk); ifc.core_input_type = 4'd7; ifc.host_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (ifc.core_readin !== 1'b0) rd++;
    end
    n_cmp++; if (err !== 1'b1 || ifc.core_set !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ill_err: err=%b set=%b busy=%b want 1 0 0", err, ifc.core_set, busy); end
    n_cmp++; if (rd !== 0 || ifc.host_ready !== 1'b0) begin n_fail++; $display("FAIL ill_readin: got %0d readin cycles want 0", rd); end
    ifc.core_input_type = 4'd0; ifc.host_valid = 1'b0;
  endtask

  task automatic test_reset_midload();
    int recv, derr, serr, nfull, gaps, lat;
    bit to;
    do_start();
    drive_load(4'd2, 1184, 1'b0, -1, 0, 500, recv, derr, serr, nfull, gaps, lat, to);
    n_cmp++; if (recv !== 500 || derr !== 0) begin n_fail++; $display("FAIL rst_pre: got %0d/%0d want 500/0", recv, derr); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (all_outs() !== '0) begin n_fail++; $display("FAIL rst_async: got %h want 0", all_outs()); end
    @(negedge clk); reset = 1'b0; ifc.core_input_type = 4'd0; ifc.host_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || ifc.core_set !== 1'b0) begin n_fail++; $display("FAIL rst_idle: busy=%b set=%b want 0 0", busy, ifc.core_set); end
    do_start();
    drive_load(4'd1, 32, 1'b0, -1, 0, 0, recv, derr, serr, nfull, gaps, lat, to);
    n_cmp++; if (recv !== 32 || derr !== 0 || nfull !== 1 || to) begin n_fail++; $display("FAIL rst_reload: got %0d bytes %0d bad want 32 0", recv, derr); end
    finish_session();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    ifc.host_valid = 1'b0; ifc.host_data = '0; ifc.core_input_type = 4'd0;
    ifc.core_readin_ok = 1'b0; ifc.core_done = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_full_session();
    test_backpressure();
    test_host_stall();
    test_type_change();
    test_illegal_type();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
